// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a byte FIFO and a status register.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADR     = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] IoReadData,
  output logic        Hit,
  output logic        tx,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d, busy_q, busy_d, overflow_q, overflow_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic            sel_data, sel_stat, full, empty, push_req, push, pop, bit_end;
  logic            unused_ok;
  assign unused_ok  = ^WriteData[31:8];
  assign sel_data   = DataAdr == BASE_ADR;
  assign sel_stat   = DataAdr == BASE_ADR + 32'd4;
  assign full       = count_q == CW'(FIFO_DEPTH);
  assign empty      = count_q == '0;
  assign push_req   = MemWrite && sel_data;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push       = push_req && (!full || pop);
  assign bit_end    = baud_q == BW'(CLKS_PER_BIT - 1);
  assign Hit        = sel_data || sel_stat;
  assign IoReadData = sel_stat ? {24'd0, 4'(count_q), overflow_q, busy_q, empty, full} : 32'd0;
  assign tx         = tx_q;
  assign busy       = busy_q;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    baud_d  = (state_q == IDLE || bit_end) ? '0 : baud_q + BW'(1);
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        shift_d = mem_q[rd_ptr_q];
        state_d = START;
        tx_d    = 1'b0;
      end
      START: if (bit_end) begin
        state_d = DATA;
        idx_d   = '0;
        tx_d    = shift_q[0];
      end
      DATA: if (bit_end) begin
        if (idx_q == 3'd7) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          tx_d    = shift_q[1];
        end
      end
      STOP: if (bit_end) begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = START;
          tx_d    = 1'b0;
        end else begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d     = state_d != IDLE;
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = (MemWrite && sel_stat) ? 1'b0 : (push_req && full && !pop) ? 1'b1 : overflow_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= WriteData[7:0];
endmodule
